// File: rtl/function_evaluation.sv
// Accumulates f(x) = 0.5*x + x^2*cos((x-128)/128) for two float operands per GO,
// using float->Q16.16 conversion, two CORDIC cosine units and a Q32.16 accumulator.
module function_evaluation #(
    parameter int DATA_W = 32,
    parameter int COEF_W = 26,
    parameter int STAGES = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_en,
    input  logic              start,
    input  logic [1:0]        n,
    input  logic [DATA_W-1:0] x_one,
    input  logic [DATA_W-1:0] x_two,
    output logic [DATA_W-1:0] result,
    output logic              done
);

    localparam int ZW    = 20;
    localparam int ACC_W = 48;

    localparam logic [1:0] OP_CLEAR = 2'd0;
    localparam logic [1:0] OP_GO    = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;

    localparam logic [3:0] CNT_CORDIC = 4'(STAGES);
    localparam logic [3:0] CNT_SQ     = 4'(STAGES + 1);
    localparam logic [3:0] CNT_F      = 4'(STAGES + 2);
    localparam logic [3:0] CNT_LAST   = 4'(STAGES + 3);

    localparam logic signed [31:0] FIX_MAX = 32'sd16711680;   // 255.0
    localparam logic signed [31:0] FIX_MIN = -32'sd4194304;   // -64.0
    localparam logic signed [31:0] FIX_MID = 32'sd8388608;    // 128.0
    // CORDIC x/y carry Q2.20 so rounding noise stays well below the angle resolution.
    localparam logic signed [COEF_W-1:0] CORDIC_K = COEF_W'(636751);

    typedef enum logic {IDLE, BUSY} state_t;

    typedef struct packed {
        logic signed [COEF_W-1:0] x;
        logic signed [COEF_W-1:0] y;
        logic signed [ZW-1:0]     z;
    } cordic_t;

    function automatic logic signed [31:0] to_fix(input logic [31:0] f);
        logic [7:0]         e;
        logic [23:0]        mant;
        logic [23:0]        mag;
        logic signed [31:0] v;
        e    = f[30:23];
        mant = {1'b1, f[22:0]};
        mag  = '0;
        v    = '0;
        if (e == 8'd0 || e == 8'hFF) begin
            v = '0;
        end else if (e >= 8'd135) begin
            v = f[31] ? FIX_MIN : FIX_MAX;
        end else begin
            if (e >= 8'd111) mag = mant >> (8'd134 - e);
            v = f[31] ? -$signed({8'b0, mag}) : $signed({8'b0, mag});
            if (v > FIX_MAX) v = FIX_MAX;
            if (v < FIX_MIN) v = FIX_MIN;
        end
        return v;
    endfunction

    function automatic logic [DATA_W-1:0] to_float(input logic signed [ACC_W-1:0] a);
        logic [ACC_W-1:0] mag;
        logic [ACC_W-1:0] norm;
        logic [5:0]       p;
        if (a == '0) return '0;
        mag = a[ACC_W-1] ? $unsigned(-a) : $unsigned(a);
        p   = '0;
        for (int i = 0; i < ACC_W; i++) if (mag[i]) p = 6'(i);
        norm = mag << (6'd47 - p);
        return {a[ACC_W-1], 8'd111 + {2'b00, p}, 23'(norm >> 24)};
    endfunction

    function automatic logic [ZW-1:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    return 20'd51472;
            4'd1:    return 20'd30386;
            4'd2:    return 20'd16055;
            4'd3:    return 20'd8150;
            4'd4:    return 20'd4091;
            4'd5:    return 20'd2047;
            4'd6:    return 20'd1024;
            4'd7:    return 20'd512;
            4'd8:    return 20'd256;
            4'd9:    return 20'd128;
            4'd10:   return 20'd64;
            4'd11:   return 20'd32;
            4'd12:   return 20'd16;
            4'd13:   return 20'd8;
            4'd14:   return 20'd4;
            default: return 20'd2;
        endcase
    endfunction

    function automatic cordic_t cordic_init(input logic signed [31:0] xq);
        logic signed [31:0] ang;
        cordic_t            r;
        ang = (xq - FIX_MID) >>> 7;
        r.x = CORDIC_K;
        r.y = '0;
        r.z = ZW'(ang);
        return r;
    endfunction

    function automatic cordic_t cordic_step(input cordic_t c, input logic [3:0] i);
        cordic_t r;
        if (c.z >= 0) begin
            r.x = c.x - (c.y >>> i);
            r.y = c.y + (c.x >>> i);
            r.z = c.z - $signed(atan_lut(i));
        end else begin
            r.x = c.x + (c.y >>> i);
            r.y = c.y - (c.x >>> i);
            r.z = c.z + $signed(atan_lut(i));
        end
        return r;
    endfunction

    state_t                    state_q, state_d;
    logic [3:0]                cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]         result_q, result_d;

    logic [1:0]                op_q;
    logic [31:0]               xa_raw_q, xb_raw_q;
    logic signed [31:0]        xqa_q, xqb_q;
    cordic_t                   ca_q, cb_q;
    logic signed [39:0]        sqa_q, sqb_q;
    logic signed [ACC_W-1:0]   fa_q, fb_q;

    logic signed [31:0]        xa_fix, xb_fix;
    logic [3:0]                it0, it1;
    logic signed [ACC_W-1:0]   acc_go;

    assign xa_fix = to_fix(xa_raw_q);
    assign xb_fix = to_fix(xb_raw_q);
    assign it0    = {cnt_q[2:0] - 3'd1, 1'b0};
    assign it1    = {cnt_q[2:0] - 3'd1, 1'b1};
    assign acc_go = acc_q + fa_q + fb_q;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        acc_d    = acc_q;
        result_d = result_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    done_d  = 1'b1;
                    case (op_q)
                        OP_CLEAR: begin
                            acc_d    = '0;
                            result_d = '0;
                        end
                        OP_GO: begin
                            acc_d    = acc_go;
                            result_d = to_float(acc_go);
                        end
                        OP_READ: result_d = to_float(acc_q);
                        default: ;
                    endcase
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            acc_q    <= '0;
            result_q <= '0;
        end else if (clk_en) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    // Datapath: latch -> convert -> CORDIC (2 iter/cycle) -> square -> f(x); committed by the FSM.
    always_ff @(posedge clk) begin
        if (clk_en) begin
            if (state_q == IDLE && start) begin
                op_q     <= n;
                xa_raw_q <= x_one;
                xb_raw_q <= x_two;
            end
            if (state_q == BUSY) begin
                if (cnt_q == 4'd0) begin
                    xqa_q <= xa_fix;
                    xqb_q <= xb_fix;
                    ca_q  <= cordic_init(xa_fix);
                    cb_q  <= cordic_init(xb_fix);
                end else if (cnt_q <= CNT_CORDIC) begin
                    ca_q <= cordic_step(cordic_step(ca_q, it0), it1);
                    cb_q <= cordic_step(cordic_step(cb_q, it0), it1);
                end else if (cnt_q == CNT_SQ) begin
                    sqa_q <= 40'((64'(xqa_q) * 64'(xqa_q)) >>> 16);
                    sqb_q <= 40'((64'(xqb_q) * 64'(xqb_q)) >>> 16);
                end else if (cnt_q == CNT_F) begin
                    fa_q <= ACC_W'((68'(sqa_q) * 68'(ca_q.x)) >>> 20) + ACC_W'(xqa_q >>> 1);
                    fb_q <= ACC_W'((68'(sqb_q) * 68'(cb_q.x)) >>> 20) + ACC_W'(xqb_q >>> 1);
                end
            end
        end
    end

    assign result = result_q;
    assign done   = done_q;

endmodule

// File: tb/tb_function_evaluation.sv
// Directed bench for function_evaluation: latency, opcodes, enable freeze, clamping and reset abort.
module tb_function_evaluation;

    logic        clk = 1'b0;
    logic        rst, clk_en, start;
    logic [1:0]  n;
    logic [31:0] x_one, x_two, result;
    logic        done;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    function_evaluation dut (
        .clk    (clk),
        .rst    (rst),
        .clk_en (clk_en),
        .start  (start),
        .n      (n),
        .x_one  (x_one),
        .x_two  (x_two),
        .result (result),
        .done   (done)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic real f2r(input logic [31:0] b);
        real m;
        int  e;
        int  mi;
        e = {24'd0, b[30:23]};
        if (e == 0) return 0.0;
        mi = {8'd0, 1'b1, b[22:0]};
        m  = mi;
        e  = e - 150;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    task automatic chk_int(input string tag, input int obs, input int exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_bits(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_real(input string tag, input logic [31:0] obs, input real exp);
        real got, diff, tol;
        logic ok;
        got  = f2r(obs);
        diff = (got > exp) ? got - exp : exp - got;
        tol  = ((exp < 0.0) ? -exp : exp) * 0.001 + 0.02;
        ok   = (diff <= tol);
        vectors++;
        assert (ok === 1'b1) else begin
            miscompares++;
            $error("FAIL %s: observed %f (%h), expected %f", tag, got, obs, exp);
        end
    endtask

    task automatic ticks_to_done(output int k);
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
    endtask

    // Accept one request, scramble the inputs, then check latency and pulse width.
    task automatic run_op(input string tag, input logic [1:0] op,
                          input logic [31:0] a, input logic [31:0] b);
        int k;
        start = 1'b1; n = op; x_one = a; x_two = b;
        tick();
        start = 1'b0; n = ~op; x_one = 32'h447A0000; x_two = 32'hC1A00000;
        ticks_to_done(k);
        chk_int({tag, "_latency"}, k, 12);
        tick();
        chk_bits({tag, "_pulse"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int k;
        int pulses;
        rst = 1'b1; clk_en = 1'b1; start = 1'b0; n = 2'd3;
        x_one = 32'h0; x_two = 32'h0;
        tick();
        tick();
        chk_bits("reset_result", result, 32'h00000000);
        chk_bits("reset_done", {31'd0, done}, 32'd0);
        rst = 1'b0;

        run_op("clear0", 2'd0, 32'h0, 32'h0);
        chk_bits("clear0_result", result, 32'h00000000);

        run_op("go_5_20", 2'd1, 32'h40A00000, 32'h41A00000);
        chk_real("go_5_20_result", result, 292.69);

        run_op("go_m20_m60", 2'd1, 32'hC1A00000, 32'hC2700000);
        chk_real("go_m20_m60_result", result, 780.53);

        // Start held while disabled, then a mid-operation freeze.
        clk_en = 1'b0; start = 1'b1; n = 2'd2; x_one = 32'h0; x_two = 32'h0;
        repeat (3) tick();
        chk_bits("en_off_no_done", {31'd0, done}, 32'd0);
        clk_en = 1'b1;
        tick();
        start = 1'b0; n = 2'd0;
        repeat (5) tick();
        clk_en = 1'b0;
        repeat (4) tick();
        chk_bits("freeze_no_done", {31'd0, done}, 32'd0);
        clk_en = 1'b1;
        ticks_to_done(k);
        chk_int("freeze_remaining", k, 7);
        clk_en = 1'b0;
        repeat (2) tick();
        chk_bits("done_held", {31'd0, done}, 32'd1);
        clk_en = 1'b1;
        tick();
        chk_bits("done_cleared", {31'd0, done}, 32'd0);
        chk_real("read_result", result, 780.53);

        // Start pulsed again while busy must be ignored.
        start = 1'b1; n = 2'd1; x_one = 32'h40A00000; x_two = 32'h41A00000;
        tick();
        start = 1'b0; n = 2'd0; x_one = 32'h43340000;
        k = 0;
        while (done !== 1'b1 && k < 40) begin
            start = (k == 3);
            tick();
            k++;
        end
        start = 1'b0;
        chk_int("busy_start_latency", k, 12);
        pulses = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk_int("busy_start_extra_done", pulses, 0);
        chk_real("busy_start_result", result, 1073.22);

        run_op("clear1", 2'd0, 32'h0, 32'h0);
        chk_bits("clear1_result", result, 32'h00000000);
        run_op("go_180_m60", 2'd1, 32'h43340000, 32'hC2700000);
        chk_real("go_180_m60_result", result, 30189.5);
        run_op("read2", 2'd2, 32'h0, 32'h0);
        chk_real("read2_result", result, 30189.5);
        run_op("nop", 2'd3, 32'h40A00000, 32'h40A00000);
        chk_real("nop_result", result, 30189.5);
        run_op("clear2", 2'd0, 32'h0, 32'h0);
        chk_bits("clear2_result", result, 32'h00000000);

        // Clamping, NaN and denormal inputs.
        run_op("go_1000_nan", 2'd1, 32'h447A0000, 32'h7FC00000);
        chk_real("clamp_hi_result", result, 35687.07);
        run_op("clear3", 2'd0, 32'h0, 32'h0);
        run_op("go_m1000_den", 2'd1, 32'hC47A0000, 32'h00000001);
        chk_real("clamp_lo_result", result, 257.74);

        // Negative accumulator.
        run_op("clear4", 2'd0, 32'h0, 32'h0);
        run_op("go_neg", 2'd1, 32'hBF000000, 32'hBF000000);
        chk_bits("neg_sign", {31'd0, result[31]}, 32'd1);
        chk_real("neg_result", result, -0.2315);

        // Reset five cycles into a GO aborts it; start on the reset edge is ignored.
        start = 1'b1; n = 2'd1; x_one = 32'h40A00000; x_two = 32'h41A00000;
        tick();
        start = 1'b0;
        repeat (5) tick();
        rst = 1'b1; start = 1'b1;
        tick();
        rst = 1'b0; start = 1'b0;
        pulses = 0;
        repeat (20) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        chk_int("rst_abort_done", pulses, 0);
        chk_bits("rst_abort_result", result, 32'h00000000);
        run_op("read_after_rst", 2'd2, 32'h0, 32'h0);
        chk_bits("read_after_rst_result", result, 32'h00000000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
